// File: rtl/npu_cube_para_code_gen.sv
// Radix-4 Booth recoder feeding the cube add tree: packs per-lane weight codes into
// lane words, ping-pongs two complete words and hands them out over valid/ready.
module npu_cube_para_code_gen #(
    parameter int DWB              = 8,
    parameter int DWB_CODE         = 12,
    parameter int NPU_CUBE_MAC_NUM = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_signed,
    input  logic                                 wgt_valid,
    output logic                                 wgt_ready,
    input  logic [DWB-1:0]                       wgt_data,
    input  logic                                 wgt_last,
    output logic                                 code_valid,
    input  logic                                 code_ready,
    output logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] add_tree_para_code,
    output logic [NPU_CUBE_MAC_NUM-1:0]          code_msb,
    output logic                                 is_signed,
    output logic                                 busy
);
    // Handshakes: a beat moves on any rising edge where valid & ready are both high;
    // valid never waits on ready, and held payloads stay stable until taken.

    localparam int LANE_W = $clog2(NPU_CUBE_MAC_NUM);
    localparam int DIGITS = DWB_CODE / 3;

    typedef logic [NPU_CUBE_MAC_NUM-1:0][DWB_CODE-1:0] word_t;

    // Each digit is {neg, mag[1:0]}; triplet 111 is a zero digit, never "negative zero".
    function automatic logic [DWB_CODE-1:0] booth_enc(input logic [DWB-1:0] w);
        logic [DWB:0]          b;
        logic [2:0]            t;
        logic [DWB_CODE-1:0]   c;
        b = {w, 1'b0};
        c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            t = b[2*i+2 -: 3];
            c[3*i +: 3] = {t[2] & ~(t[1] & t[0]), (t == 3'b011) | (t == 3'b100), t[1] ^ t[0]};
        end
        return c;
    endfunction

    logic [LANE_W-1:0]                lane_cnt_q, lane_cnt_d;
    logic                             wr_ptr_q, wr_ptr_d;
    logic                             rd_ptr_q, rd_ptr_d;
    logic [1:0]                       count_q, count_d;
    logic                             sign_fill_q, sign_fill_d;
    word_t [1:0]                      bank_code_q, bank_code_d;
    logic [1:0][NPU_CUBE_MAC_NUM-1:0] bank_msb_q, bank_msb_d;
    logic [1:0]                       bank_sign_q, bank_sign_d;
    logic                             wgt_ready_q, wgt_ready_d;
    logic                             code_valid_q, code_valid_d;
    word_t                            code_q, code_d;
    logic [NPU_CUBE_MAC_NUM-1:0]      msb_q, msb_d;
    logic                             is_signed_q, is_signed_d;
    logic                             busy_q, busy_d;

    logic accept, commit, xfer, signed_eff;

    always_comb begin
        accept      = wgt_valid & wgt_ready_q;
        commit      = accept & ((lane_cnt_q == LANE_W'(NPU_CUBE_MAC_NUM - 1)) | wgt_last);
        xfer        = code_valid_q & code_ready;
        signed_eff  = (lane_cnt_q == '0) ? cfg_signed : sign_fill_q;

        lane_cnt_d  = lane_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sign_fill_d = sign_fill_q;
        bank_code_d = bank_code_q;
        bank_msb_d  = bank_msb_q;
        bank_sign_d = bank_sign_q;

        if (accept) begin
            bank_code_d[wr_ptr_q][lane_cnt_q] = booth_enc(wgt_data);
            bank_msb_d[wr_ptr_q][lane_cnt_q]  = wgt_data[DWB-1] & ~signed_eff;
            bank_sign_d[wr_ptr_q]             = signed_eff;
            sign_fill_d                       = signed_eff;
            lane_cnt_d                        = lane_cnt_q + LANE_W'(1);
        end

        // A short word zero-pads every lane above the one just written.
        if (commit) begin
            for (int k = 0; k < NPU_CUBE_MAC_NUM; k++) begin
                if (LANE_W'(k) > lane_cnt_q) begin
                    bank_code_d[wr_ptr_q][k] = '0;
                    bank_msb_d[wr_ptr_q][k]  = 1'b0;
                end
            end
            lane_cnt_d = '0;
            wr_ptr_d   = ~wr_ptr_q;
        end

        if (xfer) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({commit, xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        wgt_ready_d  = (count_d != 2'd2);
        code_valid_d = (count_d != 2'd0);
        code_d       = code_valid_d ? bank_code_d[rd_ptr_d] : '0;
        msb_d        = code_valid_d ? bank_msb_d[rd_ptr_d] : '0;
        is_signed_d  = code_valid_d & bank_sign_d[rd_ptr_d];
        busy_d       = (lane_cnt_d != '0) | code_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_q   <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            sign_fill_q  <= 1'b0;
            bank_code_q  <= '0;
            bank_msb_q   <= '0;
            bank_sign_q  <= '0;
            wgt_ready_q  <= 1'b0;
            code_valid_q <= 1'b0;
            code_q       <= '0;
            msb_q        <= '0;
            is_signed_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sign_fill_q  <= sign_fill_d;
            bank_code_q  <= bank_code_d;
            bank_msb_q   <= bank_msb_d;
            bank_sign_q  <= bank_sign_d;
            wgt_ready_q  <= wgt_ready_d;
            code_valid_q <= code_valid_d;
            code_q       <= code_d;
            msb_q        <= msb_d;
            is_signed_q  <= is_signed_d;
            busy_q       <= busy_d;
        end
    end

    assign wgt_ready          = wgt_ready_q;
    assign code_valid         = code_valid_q;
    assign add_tree_para_code = code_q;
    assign code_msb           = msb_q;
    assign is_signed          = is_signed_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_npu_cube_para_code_gen.sv
// Directed bench for the Booth parameter-code generator: hand-computed lane words,
// backpressure, short words, commit/transfer overlap and mid-stream reset.
module tb_npu_cube_para_code_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_signed;
    logic        wgt_valid;
    logic        wgt_ready;
    logic [7:0]  wgt_data;
    logic        wgt_last;
    logic        code_valid;
    logic        code_ready;
    logic [95:0] add_tree_para_code;
    logic [7:0]  code_msb;
    logic        is_signed;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    npu_cube_para_code_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_signed         (cfg_signed),
        .wgt_valid          (wgt_valid),
        .wgt_ready          (wgt_ready),
        .wgt_data           (wgt_data),
        .wgt_last           (wgt_last),
        .code_valid         (code_valid),
        .code_ready         (code_ready),
        .add_tree_para_code (add_tree_para_code),
        .code_msb           (code_msb),
        .is_signed          (is_signed),
        .busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk96(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one weight and return #1 after the edge that accepts it (valid left high).
    task automatic push(input logic [7:0] d, input logic last);
        int g;
        g = 0;
        wgt_valid = 1'b1;
        wgt_data  = d;
        wgt_last  = last;
        while (wgt_ready !== 1'b1 && g < 50) begin
            step();
            g++;
        end
        chk1("push_ready", wgt_ready, 1'b1);
        step();
    endtask

    task automatic check_word(input string tag, input logic [95:0] c, input logic [7:0] m,
                              input logic s);
        chk1({tag, "_valid"}, code_valid, 1'b1);
        chk96({tag, "_code"}, add_tree_para_code, c);
        chk8({tag, "_msb"}, code_msb, m);
        chk1({tag, "_signed"}, is_signed, s);
    endtask

    // Independent digit decode: sum of +/-mag * 4^i.
    function automatic int dec(input logic [11:0] c);
        int s;
        int m;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            m = c[3*i+1] ? 2 : (c[3*i] ? 1 : 0);
            if (c[3*i+2]) m = -m;
            s += m * (1 << (2 * i));
        end
        return s;
    endfunction

    logic [7:0]  w1 [8];
    logic [95:0] e1;
    logic [11:0] ln;
    int          c0;

    initial begin
        w1 = '{8'h5A, 8'hFF, 8'h80, 8'h00, 8'h01, 8'h7F, 8'hFE, 8'h03};
        e1 = 96'h00D_006_405_001_000_C00_005_2AE;

        rst_n      = 1'b0;
        cfg_signed = 1'b0;
        wgt_valid  = 1'b0;
        wgt_data   = 8'h00;
        wgt_last   = 1'b0;
        code_ready = 1'b0;
        #12;
        chk1("rst_ready", wgt_ready, 1'b0);
        chk1("rst_valid", code_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk96("rst_code", add_tree_para_code, 96'h0);
        chk8("rst_msb", code_msb, 8'h00);
        chk1("rst_signed", is_signed, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("rel_ready_low", wgt_ready, 1'b0);
        step();
        chk1("rel_ready_high", wgt_ready, 1'b1);

        // Signed mixed word, one weight per cycle, one-cycle latency.
        cfg_signed = 1'b1;
        code_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 7; i++) begin
            push(w1[i], 1'b0);
            chk1("t1_fill_valid", code_valid, 1'b0);
            chk1("t1_fill_busy", busy, 1'b1);
        end
        push(w1[7], 1'b0);
        wgt_valid = 1'b0;
        chki("t1_rate", cyc - c0, 8);
        check_word("t1", e1, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            ln = add_tree_para_code[12*k +: 12];
            chki("t1_dec", dec(ln), int'($signed(w1[k])));
        end
        step();
        chk1("t1_drained", code_valid, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // Unsigned 0xFF lanes: digits say -1, correction bit restores 255.
        cfg_signed = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hFF, 1'b0);
        wgt_valid = 1'b0;
        check_word("t2", {8{12'h005}}, 8'hFF, 1'b0);
        for (int k = 0; k < 8; k++) begin
            ln = add_tree_para_code[12*k +: 12];
            chki("t2_unsigned", dec(ln) + 256 * int'(code_msb[k]), 255);
        end
        step();

        // Backpressure: two words fill both banks, input stalls, then drain in order.
        cfg_signed = 1'b1;
        code_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h01, 1'b0);
        for (int i = 0; i < 8; i++) push(8'h04, 1'b0);
        wgt_valid = 1'b1;
        wgt_data  = 8'hAA;
        chk1("t3_full_ready", wgt_ready, 1'b0);
        check_word("t3_w0", {8{12'h001}}, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("t3_stall_ready", wgt_ready, 1'b0);
            chk96("t3_stall_code", add_tree_para_code, {8{12'h001}});
            chk1("t3_stall_valid", code_valid, 1'b1);
        end
        wgt_valid  = 1'b0;
        code_ready = 1'b1;
        step();
        check_word("t3_w1", {8{12'h008}}, 8'h00, 1'b1);
        chk1("t3_ready_back", wgt_ready, 1'b1);
        step();
        chk1("t3_empty", code_valid, 1'b0);
        for (int i = 0; i < 8; i++) push(8'h10, 1'b0);
        wgt_valid = 1'b0;
        check_word("t3_w2", {8{12'h040}}, 8'h00, 1'b1);
        step();

        // Short word ending on lane 2, then a word ending on lane 0.
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        wgt_valid = 1'b0;
        check_word("t4_short", 96'h000000000000000_00D_00E_001, 8'h00, 1'b1);
        chk1("t4_busy_after", busy, 1'b1);
        step();
        chk1("t4_idle", busy, 1'b0);
        push(8'h7F, 1'b1);
        wgt_valid = 1'b0;
        check_word("t4_lane0", 96'h000000000000000000000405, 8'h00, 1'b1);
        step();

        // Signedness sampled on lane 0 only.
        cfg_signed = 1'b1;
        push(8'h80, 1'b0);
        cfg_signed = 1'b0;
        push(8'h80, 1'b1);
        wgt_valid = 1'b0;
        check_word("t5_s", 96'h000000000000000000C00C00, 8'h00, 1'b1);
        step();
        cfg_signed = 1'b0;
        push(8'h80, 1'b0);
        cfg_signed = 1'b1;
        push(8'h80, 1'b1);
        wgt_valid = 1'b0;
        check_word("t5_u", 96'h000000000000000000C00C00, 8'h03, 1'b0);
        step();

        // Commit of word B on the same edge word A is taken: no bubble.
        cfg_signed = 1'b1;
        code_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h01, 1'b0);
        for (int i = 0; i < 7; i++) push(8'h04, 1'b0);
        check_word("t6_a", {8{12'h001}}, 8'h00, 1'b1);
        code_ready = 1'b1;
        push(8'h04, 1'b0);
        wgt_valid = 1'b0;
        check_word("t6_b", {8{12'h008}}, 8'h00, 1'b1);
        chk1("t6_ready", wgt_ready, 1'b1);
        step();
        chk1("t6_empty", code_valid, 1'b0);

        // Reset with one full bank and a partial word pending.
        code_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) push(8'h04, 1'b0);
        wgt_valid = 1'b0;
        chk1("t7_pre_busy", busy, 1'b1);
        chk1("t7_pre_valid", code_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t7_rst_valid", code_valid, 1'b0);
        chk1("t7_rst_busy", busy, 1'b0);
        chk1("t7_rst_ready", wgt_ready, 1'b0);
        chk96("t7_rst_code", add_tree_para_code, 96'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk1("t7_rel_ready", wgt_ready, 1'b1);
        chk1("t7_rel_valid", code_valid, 1'b0);
        chk1("t7_rel_busy", busy, 1'b0);
        code_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(w1[i], 1'b0);
        wgt_valid = 1'b0;
        check_word("t7_fresh", e1, 8'h00, 1'b1);
        step();
        chk1("t7_drained", code_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
